// File: rtl/btb_update_ctrl_if.sv
// Bundled request, BTB write-port and status signals of btb_update_ctrl.
// BTB_UPD_STATS_EN adds the issued/coalesced/blocked statistic counters.
interface btb_update_ctrl_if #(
  parameter int PTR_W = 2
);
  logic             ex_valid;
  logic             ex_ready;
  logic [31:0]      ex_pc;
  logic [31:0]      ex_target;
  logic             id_valid;
  logic             id_ready;
  logic [31:0]      id_pc;
  logic [31:0]      id_target;
  logic             flush;
  logic             btb_stall;
  logic             btb_write;
  logic [31:0]      btb_pc;
  logic [31:0]      btb_target;
  logic             btb_branch;
  logic [PTR_W:0]   count;
  logic             full;
`ifdef BTB_UPD_STATS_EN
  logic [15:0]      issued_cnt;
  logic [15:0]      coalesced_cnt;
  logic [15:0]      blocked_cnt;

  modport master (
    output ex_valid, ex_pc, ex_target, id_valid, id_pc, id_target, flush, btb_stall,
    input  ex_ready, id_ready, btb_write, btb_pc, btb_target, btb_branch, count, full,
    input  issued_cnt, coalesced_cnt, blocked_cnt
  );
  modport slave (
    input  ex_valid, ex_pc, ex_target, id_valid, id_pc, id_target, flush, btb_stall,
    output ex_ready, id_ready, btb_write, btb_pc, btb_target, btb_branch, count, full,
    output issued_cnt, coalesced_cnt, blocked_cnt
  );
`else
  modport master (
    output ex_valid, ex_pc, ex_target, id_valid, id_pc, id_target, flush, btb_stall,
    input  ex_ready, id_ready, btb_write, btb_pc, btb_target, btb_branch, count, full
  );
  modport slave (
    input  ex_valid, ex_pc, ex_target, id_valid, id_pc, id_target, flush, btb_stall,
    output ex_ready, id_ready, btb_write, btb_pc, btb_target, btb_branch, count, full
  );
`endif
endinterface

// File: rtl/btb_update_ctrl.sv
// BTB update scheduler: EX/ID request FIFO with tail coalescing, one BTB write per cycle.
// Optional statistics counters are enabled with BTB_UPD_STATS_EN.
module btb_update_ctrl #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  btb_update_ctrl_if.slave   bus
);
  localparam logic [PTR_W:0] LP_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] LP_ONE  = (PTR_W+1)'(1);

  logic [31:0]      r_pc_mem  [DEPTH];
  logic [31:0]      r_tgt_mem [DEPTH];
  logic             r_br_mem  [DEPTH];

  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W:0]   r_count;
  logic             r_btb_write;
  logic [31:0]      r_btb_pc;
  logic [31:0]      r_btb_target;
  logic             r_btb_branch;

  logic             w_full;
  logic             w_nonempty;
  logic             w_pop;
  logic [PTR_W-1:0] w_tail_idx;
  logic [PTR_W-1:0] w_wr_idx;
  logic [31:0]      w_in_pc;
  logic [31:0]      w_in_target;
  logic             w_in_branch;
  logic             w_tail_popped;
  logic             w_hit;
  logic             w_accept_ok;
  logic             w_ex_ready;
  logic             w_id_ready;
  logic             w_enq;
  logic             w_push;

  assign w_full        = (r_count == LP_FULL);
  assign w_nonempty    = (r_count != '0);
  assign w_pop         = w_nonempty & ~bus.btb_stall & ~bus.flush;
  assign w_tail_idx    = r_tail - 1'b1;

  // EX wins the single enqueue slot, so the compare uses whichever source is selected
  assign w_in_pc       = bus.ex_valid ? bus.ex_pc     : bus.id_pc;
  assign w_in_target   = bus.ex_valid ? bus.ex_target : bus.id_target;
  assign w_in_branch   = bus.ex_valid;

  // With one entry left the tail is also the head; merging into it while it issues would be lost
  assign w_tail_popped = w_pop & (r_count == LP_ONE);
  assign w_hit         = w_nonempty & (w_in_pc == r_pc_mem[w_tail_idx]) & ~w_tail_popped;

  assign w_accept_ok   = ~bus.flush & (~w_full | w_hit);
  assign w_ex_ready    = bus.ex_valid & w_accept_ok;
  assign w_id_ready    = bus.id_valid & ~bus.ex_valid & w_accept_ok;
  assign w_enq         = w_ex_ready | w_id_ready;
  assign w_push        = w_enq & ~w_hit;
  assign w_wr_idx      = w_hit ? w_tail_idx : r_tail;

  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_pc_mem[w_wr_idx]  <= w_in_pc;
      r_tgt_mem[w_wr_idx] <= w_in_target;
      r_br_mem[w_wr_idx]  <= w_in_branch;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (bus.flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      r_count <= r_count + (PTR_W+1)'(w_push) - (PTR_W+1)'(w_pop);
    end
  end

  // Write strobe is registered; the data registers hold between issues
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_btb_write  <= 1'b0;
      r_btb_pc     <= '0;
      r_btb_target <= '0;
      r_btb_branch <= 1'b1;
    end else begin
      r_btb_write <= w_pop;
      if (w_pop) begin
        r_btb_pc     <= r_pc_mem[r_head];
        r_btb_target <= r_tgt_mem[r_head];
        r_btb_branch <= r_br_mem[r_head];
      end
    end
  end

  assign bus.ex_ready   = w_ex_ready;
  assign bus.id_ready   = w_id_ready;
  assign bus.btb_write  = r_btb_write;
  assign bus.btb_pc     = r_btb_pc;
  assign bus.btb_target = r_btb_target;
  assign bus.btb_branch = r_btb_branch;
  assign bus.count      = r_count;
  assign bus.full       = w_full;

`ifdef BTB_UPD_STATS_EN
  logic [15:0] r_issued_cnt;
  logic [15:0] r_coalesced_cnt;
  logic [15:0] r_blocked_cnt;
  logic        w_blocked;

  assign w_blocked = (bus.ex_valid | bus.id_valid) & ~w_enq;

  // Saturating counters; flush clears them like the queue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_issued_cnt    <= '0;
      r_coalesced_cnt <= '0;
      r_blocked_cnt   <= '0;
    end else if (bus.flush) begin
      r_issued_cnt    <= '0;
      r_coalesced_cnt <= '0;
      r_blocked_cnt   <= '0;
    end else begin
      if (r_btb_write && r_issued_cnt != 16'hFFFF)     r_issued_cnt    <= r_issued_cnt + 16'd1;
      if (w_enq && w_hit && r_coalesced_cnt != 16'hFFFF) r_coalesced_cnt <= r_coalesced_cnt + 16'd1;
      if (w_blocked && r_blocked_cnt != 16'hFFFF)      r_blocked_cnt   <= r_blocked_cnt + 16'd1;
    end
  end

  assign bus.issued_cnt    = r_issued_cnt;
  assign bus.coalesced_cnt = r_coalesced_cnt;
  assign bus.blocked_cnt   = r_blocked_cnt;
`endif
endmodule

// File: tb/tb_btb_update_ctrl.sv
// Randomized and directed bench for btb_update_ctrl against a queue-based reference model.
module tb_btb_update_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  btb_update_ctrl_if #(.PTR_W(2)) bus ();

  btb_update_ctrl #(.DEPTH(4), .PTR_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        br;
  } ent_t;

  ent_t        q[$];
  logic        exp_write;
  logic [31:0] exp_pc;
  logic [31:0] exp_tgt;
  logic        exp_br;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    exp_write = 1'b0;
    exp_pc    = '0;
    exp_tgt   = '0;
    exp_br    = 1'b1;
  endtask

  // One clock cycle: check registered state, apply inputs, check readies, advance model
  task automatic step(input logic ev, input logic [31:0] epc, input logic [31:0] etg,
                      input logic iv, input logic [31:0] ipc, input logic [31:0] itg,
                      input logic fl, input logic st);
    bit          pop, hit, ok, e_er, e_ir;
    logic [31:0] in_pc, in_tgt;
    ent_t        e, head;
    @(negedge clk);
    chk("count", 32'(bus.count), 32'(q.size()));
    chk("full", 32'(bus.full), 32'(q.size() == 4));
    chk("btb_write", 32'(bus.btb_write), 32'(exp_write));
    chk("btb_pc", bus.btb_pc, exp_pc);
    chk("btb_target", bus.btb_target, exp_tgt);
    chk("btb_branch", 32'(bus.btb_branch), 32'(exp_br));
    bus.ex_valid = ev;  bus.ex_pc = epc;  bus.ex_target = etg;
    bus.id_valid = iv;  bus.id_pc = ipc;  bus.id_target = itg;
    bus.flush = fl;     bus.btb_stall = st;
    #1;
    pop    = (q.size() > 0) && !st && !fl;
    in_pc  = ev ? epc : ipc;
    in_tgt = ev ? etg : itg;
    hit    = (q.size() > 0) && (q[$].pc == in_pc) && !(pop && q.size() == 1);
    ok     = !fl && ((q.size() < 4) || hit);
    e_er   = ev && ok;
    e_ir   = iv && !ev && ok;
    chk("ex_ready", 32'(bus.ex_ready), 32'(e_er));
    chk("id_ready", 32'(bus.id_ready), 32'(e_ir));
    @(posedge clk);
    if (fl) begin
      q.delete();
      exp_write = 1'b0;
    end else begin
      if (pop) head = q[0];
      if (e_er || e_ir) begin
        e.pc = in_pc; e.tgt = in_tgt; e.br = ev;
        if (hit) q[q.size()-1] = e;
        else     q.push_back(e);
      end
      if (pop) begin
        exp_write = 1'b1;
        exp_pc    = head.pc;
        exp_tgt   = head.tgt;
        exp_br    = head.br;
        void'(q.pop_front());
      end else begin
        exp_write = 1'b0;
      end
    end
  endtask

  task automatic idle(input logic st);
    step(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, st);
  endtask

  task automatic ex_req(input logic [31:0] pc, input logic [31:0] tg, input logic st);
    step(1'b1, pc, tg, 1'b0, 32'h0, 32'h0, 1'b0, st);
  endtask

  initial begin
    logic        ev, iv, fl, st;
    logic [31:0] epc, ipc;
    rst_n = 1'b0;
    bus.ex_valid = 0; bus.ex_pc = 0; bus.ex_target = 0;
    bus.id_valid = 0; bus.id_pc = 0; bus.id_target = 0;
    bus.flush = 0;    bus.btb_stall = 0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // single EX request, written one cycle after enqueue
    ex_req(32'h100, 32'h140, 1'b0);
    idle(1'b0);
    idle(1'b0);
    $display("txn single_ex done count=%0d", bus.count);

    // EX priority over ID, ID accepted next cycle
    step(1'b1, 32'h200, 32'h210, 1'b1, 32'h300, 32'h310, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 32'h300, 32'h310, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b0);
    $display("txn ex_id_priority done");

    // fill under stall, blocked 5th request, coalesce into full tail, drain
    ex_req(32'h100, 32'h1a0, 1'b1);
    ex_req(32'h200, 32'h2a0, 1'b1);
    ex_req(32'h300, 32'h3a0, 1'b1);
    ex_req(32'h400, 32'h4a0, 1'b1);
    ex_req(32'h500, 32'h5a0, 1'b1);
    ex_req(32'h400, 32'h480, 1'b1);
    repeat (6) idle(1'b0);
    $display("txn full_coalesce done");

    // flush with three queued entries and a request in the flush cycle
    ex_req(32'h600, 32'h6a0, 1'b1);
    ex_req(32'h700, 32'h7a0, 1'b1);
    ex_req(32'h800, 32'h8a0, 1'b1);
    step(1'b1, 32'h900, 32'h9a0, 1'b1, 32'ha00, 32'ha10, 1'b1, 1'b0);
    repeat (3) idle(1'b0);
    $display("txn flush done");

    // asynchronous reset while a write strobe is high
    ex_req(32'hb00, 32'hb40, 1'b0);
    ex_req(32'hc00, 32'hc40, 1'b0);
    @(negedge clk);
    chk("pre_rst_write", 32'(bus.btb_write), 32'(exp_write));
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_write", 32'(bus.btb_write), 32'h0);
    chk("async_rst_count", 32'(bus.count), 32'h0);
    chk("async_rst_full", 32'(bus.full), 32'h0);
    bus.ex_valid = 0; bus.id_valid = 0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    $display("txn async_reset done");

    // randomized traffic with a small PC pool to provoke coalescing
    for (int i = 0; i < 600; i++) begin
      ev  = ($urandom_range(0, 9) < 6);
      iv  = ($urandom_range(0, 9) < 5);
      epc = 32'h100 * (1 + $urandom_range(0, 5));
      ipc = 32'h100 * (1 + $urandom_range(0, 5));
      fl  = ($urandom_range(0, 29) == 0);
      st  = ((i / 20) % 2 == 0) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 2);
      step(ev, epc, $urandom, iv, ipc, $urandom, fl, st);
      if (i % 50 == 0) $display("txn random i=%0d count=%0d", i, bus.count);
    end
    repeat (6) idle(1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
